// File: rtl/processor_pkg.sv
// Shared types for the staged processor core: pipeline controller state encoding
// and the supported pipeline depth limit.
package processor_pkg;

  typedef enum logic [1:0] {
    PC_RUN,
    PC_DRAIN,
    PC_HALTED
  } pipe_state_t;

  localparam int MAX_STAGES = 8;

endpackage

// File: rtl/pipeline_stage_reg.sv
// One pipeline occupancy slot: valid bit plus the instruction IP it carries.
// Latency: 1 cycle. Backpressure: hold freezes the slot; flush clears valid on load.
module pipeline_stage_reg
  import processor_pkg::*;
#(
  parameter int ADDR_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 hold,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [ADDR_SIZE-1:0] in_ip,
  output logic                 valid,
  output logic [ADDR_SIZE-1:0] ip
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      ip    <= '0;
    end else if (!hold) begin
      valid <= in_valid & ~flush;
      ip    <= in_ip;
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Fetch IP and per-stage valid/IP chain with redirect flush, stall and wait/continue halt.
// Latency: one cycle per stage, code_addr is the IP register; redirect costs DECODE_STAGE bubbles.
// Backpressure: stall freezes every register; PIPELINE_DEBUG_HALT_EN adds debug_halt/debug_halted.
module pipeline_control
  import processor_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter int DECODE_STAGE = 1,
  parameter int ADDR_SIZE    = 18,
  parameter int WAIT_CNT_W   = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            redirect_valid,
  input  logic [ADDR_SIZE-1:0]            redirect_ip,
  input  logic                            wait_detect,
  input  logic                            wait_continue_execution,
`ifdef PIPELINE_DEBUG_HALT_EN
  input  logic                            debug_halt,
  output logic                            debug_halted,
`endif
  output logic [ADDR_SIZE-1:0]            code_addr,
  output logic [NUM_STAGES-1:0]           stage_valid,
  output logic [NUM_STAGES*ADDR_SIZE-1:0] stage_ip,
  output logic                            wait_for_continue,
  output logic [WAIT_CNT_W-1:0]           wait_cycles
);

  pipe_state_t            state, state_nxt;
  logic [ADDR_SIZE-1:0]   ip_q, ip_nxt;
  logic [ADDR_SIZE-1:0]   wait_ip_q, wait_ip_nxt;
  logic                   fetch_en;
  logic                   clr_wait_cnt;
  logic                   older_vld;
  int                     kill_top;
  logic [NUM_STAGES-1:0]  flush_vec;
  logic [NUM_STAGES-1:0]  stg_vld;
  logic [ADDR_SIZE-1:0]   stg_ip [NUM_STAGES];
`ifdef PIPELINE_DEBUG_HALT_EN
  logic                   halt_by_wait_q, halt_by_wait_nxt;
`endif

  // Anything still live past decode must retire before the core counts as halted.
  always_comb begin
    older_vld = 1'b0;
    for (int k = DECODE_STAGE + 1; k < NUM_STAGES; k++) older_vld |= stg_vld[k];
  end

  always_comb begin
    state_nxt    = state;
    ip_nxt       = ip_q;
    wait_ip_nxt  = wait_ip_q;
    fetch_en     = 1'b0;
    clr_wait_cnt = 1'b0;
    kill_top     = -1;
`ifdef PIPELINE_DEBUG_HALT_EN
    halt_by_wait_nxt = halt_by_wait_q;
`endif
    unique case (state)
      PC_RUN: begin
        if (redirect_valid) begin
          ip_nxt   = redirect_ip;
          kill_top = DECODE_STAGE - 1;
        end else if (wait_detect && !wait_continue_execution) begin
          // The wait itself retires at decode, so it is dropped along with younger slots.
          wait_ip_nxt  = stg_ip[DECODE_STAGE];
          kill_top     = DECODE_STAGE + 1;
          state_nxt    = PC_DRAIN;
          clr_wait_cnt = 1'b1;
`ifdef PIPELINE_DEBUG_HALT_EN
          halt_by_wait_nxt = 1'b1;
        end else if (debug_halt) begin
          wait_ip_nxt      = ip_q - ADDR_SIZE'(1);
          kill_top         = DECODE_STAGE;
          state_nxt        = PC_DRAIN;
          clr_wait_cnt     = 1'b1;
          halt_by_wait_nxt = 1'b0;
`endif
        end else begin
          fetch_en = 1'b1;
          ip_nxt   = ip_q + ADDR_SIZE'(1);
        end
      end
      PC_DRAIN: begin
        kill_top = DECODE_STAGE;
        if (!older_vld) state_nxt = PC_HALTED;
      end
      PC_HALTED: begin
        kill_top = DECODE_STAGE;
`ifdef PIPELINE_DEBUG_HALT_EN
        if (!debug_halt && (!halt_by_wait_q || wait_continue_execution)) begin
`else
        if (wait_continue_execution) begin
`endif
          ip_nxt    = wait_ip_q + ADDR_SIZE'(1);
          state_nxt = PC_RUN;
        end
      end
      default: state_nxt = PC_RUN;
    endcase
    for (int k = 0; k < NUM_STAGES; k++) flush_vec[k] = (k <= kill_top);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= PC_RUN;
      ip_q              <= '0;
      wait_ip_q         <= '0;
      wait_for_continue <= 1'b0;
    end else if (!stall) begin
      state             <= state_nxt;
      ip_q              <= ip_nxt;
      wait_ip_q         <= wait_ip_nxt;
      wait_for_continue <= (state_nxt == PC_HALTED);
    end
  end

  // Halted time keeps accumulating through stall; only a new halt clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cycles <= '0;
    end else if (clr_wait_cnt && !stall) begin
      wait_cycles <= '0;
    end else if (state == PC_HALTED && wait_cycles != '1) begin
      wait_cycles <= wait_cycles + WAIT_CNT_W'(1);
    end
  end

`ifdef PIPELINE_DEBUG_HALT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halt_by_wait_q <= 1'b0;
    end else if (!stall) begin
      halt_by_wait_q <= halt_by_wait_nxt;
    end
  end

  assign debug_halted = (state == PC_HALTED) && debug_halt;
`endif

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic                 in_vld;
    logic [ADDR_SIZE-1:0] in_ip;

    if (k == 0) begin : g_head
      assign in_vld = fetch_en;
      assign in_ip  = ip_q;
    end else begin : g_body
      assign in_vld = stg_vld[k-1];
      assign in_ip  = stg_ip[k-1];
    end

    pipeline_stage_reg #(
      .ADDR_SIZE (ADDR_SIZE)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .hold     (stall),
      .flush    (flush_vec[k]),
      .in_valid (in_vld),
      .in_ip    (in_ip),
      .valid    (stg_vld[k]),
      .ip       (stg_ip[k])
    );

    assign stage_ip[k*ADDR_SIZE +: ADDR_SIZE] = stg_ip[k];
  end

  assign stage_valid = stg_vld;
  assign code_addr   = ip_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboarded bench for pipeline_control: directed scenarios then random traffic
// against an array-based reference model of fetch, flush, drain and halt.
module tb_pipeline_control;

  localparam int NS = 3;
  localparam int DS = 1;
  localparam int AW = 18;
  localparam int WW = 16;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_ip = '0;
  logic          wait_detect = 1'b0;
  logic          wait_continue_execution = 1'b0;
  logic [AW-1:0] code_addr;
  logic [NS-1:0] stage_valid;
  logic [NS*AW-1:0] stage_ip;
  logic          wait_for_continue;
  logic [WW-1:0] wait_cycles;
`ifdef PIPELINE_DEBUG_HALT_EN
  logic          debug_halted;
`endif

  always #5 clock = ~clock;

  pipeline_control #(
    .NUM_STAGES   (NS),
    .DECODE_STAGE (DS),
    .ADDR_SIZE    (AW),
    .WAIT_CNT_W   (WW)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .stall                   (stall),
    .redirect_valid          (redirect_valid),
    .redirect_ip             (redirect_ip),
    .wait_detect             (wait_detect),
    .wait_continue_execution (wait_continue_execution),
`ifdef PIPELINE_DEBUG_HALT_EN
    .debug_halt              (1'b0),
    .debug_halted            (debug_halted),
`endif
    .code_addr               (code_addr),
    .stage_valid             (stage_valid),
    .stage_ip                (stage_ip),
    .wait_for_continue       (wait_for_continue),
    .wait_cycles             (wait_cycles)
  );

  typedef struct packed {
    logic [AW-1:0]    ca;
    logic [NS-1:0]    sv;
    logic [NS*AW-1:0] sip;
    logic             wfc;
    logic [WW-1:0]    wc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: IP, mode, and the instruction held by each stage.
  int            m_mode;
  logic [AW-1:0] m_ip, m_wip;
  logic [WW-1:0] m_wc;
  logic          m_v [NS];
  logic [AW-1:0] m_p [NS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_ip   = '0;
    m_wip  = '0;
    m_wc   = '0;
    for (int k = 0; k < NS; k++) begin
      m_v[k] = 1'b0;
      m_p[k] = '0;
    end
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [AW-1:0] rip,
                            input logic wd, input logic wc);
    logic          nv [NS];
    logic [AW-1:0] np [NS];
    bit            older;
    int            kill_upto;
    if (st) begin
      if (m_mode == M_HALT && m_wc != '1) m_wc = m_wc + WW'(1);
      return;
    end
    older = 1'b0;
    for (int k = DS + 1; k < NS; k++) older |= m_v[k];
    nv[0] = 1'b0;
    np[0] = m_ip;
    for (int k = 1; k < NS; k++) begin
      nv[k] = m_v[k-1];
      np[k] = m_p[k-1];
    end
    kill_upto = -1;
    if (m_mode == M_RUN) begin
      if (rv) begin
        kill_upto = DS - 1;
        m_ip      = rip;
      end else if (wd && !wc) begin
        m_wip     = m_p[DS];
        kill_upto = DS + 1;
        m_mode    = M_DRAIN;
        m_wc      = '0;
      end else begin
        nv[0] = 1'b1;
        m_ip  = m_ip + AW'(1);
      end
    end else if (m_mode == M_DRAIN) begin
      kill_upto = DS;
      if (!older) m_mode = M_HALT;
    end else begin
      kill_upto = DS;
      if (m_wc != '1) m_wc = m_wc + WW'(1);
      if (wc) begin
        m_ip   = m_wip + AW'(1);
        m_mode = M_RUN;
      end
    end
    for (int k = 0; k < NS; k++) begin
      m_v[k] = nv[k] && (k > kill_upto);
      m_p[k] = np[k];
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.ca  = m_ip;
    e.wfc = (m_mode == M_HALT);
    e.wc  = m_wc;
    for (int k = 0; k < NS; k++) begin
      e.sv[k]           = m_v[k];
      e.sip[k*AW +: AW] = m_p[k];
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("code_addr", 64'(code_addr), 64'(e.ca));
      chk("stage_valid", 64'(stage_valid), 64'(e.sv));
      for (int k = 0; k < NS; k++)
        if (e.sv[k]) chk("stage_ip", 64'(stage_ip[k*AW +: AW]), 64'(e.sip[k*AW +: AW]));
      chk("wait_for_continue", 64'(wait_for_continue), 64'(e.wfc));
      chk("wait_cycles", 64'(wait_cycles), 64'(e.wc));
    end
  end

  task automatic cyc(input logic st, input logic rv, input logic [AW-1:0] rip,
                     input logic wd, input logic wc);
    @(negedge clock);
    #1;
    stall                   = st;
    redirect_valid          = rv;
    redirect_ip             = rip;
    wait_detect             = wd;
    wait_continue_execution = wc;
    @(posedge clock);
    model_step(st, rv, rip, wd, wc);
    push_exp();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Reset asserts mid-cycle so the asynchronous clear is visible before any edge.
  task automatic do_reset();
    @(negedge clock);
    #2;
    reset                   = 1'b0;
    stall                   = 1'b0;
    redirect_valid          = 1'b0;
    wait_detect             = 1'b0;
    wait_continue_execution = 1'b0;
    #1;
    chk("rst_code_addr", 64'(code_addr), 64'd0);
    chk("rst_stage_valid", 64'(stage_valid), 64'd0);
    chk("rst_stage_ip", 64'(stage_ip), 64'd0);
    chk("rst_wait_for_continue", 64'(wait_for_continue), 64'd0);
    chk("rst_wait_cycles", 64'(wait_cycles), 64'd0);
    exp_q.delete();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic halt_latency(input int nstall, input int want, input string nm);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < nstall; i++) begin
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
      n++;
      if (wait_for_continue) seen = 1'b1;
    end
    chk(nm, 64'(seen ? n : 999), 64'(want));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic          st, rv, wd, wc;
    logic [AW-1:0] rip;
    int            r;

    do_reset();
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      chk("fetch_seq", 64'(code_addr), 64'(i));
    end
    chk("fill_valid", 64'(stage_valid), 64'h7);
    idle(4);
    chk("pre_redirect_ip1", 64'(stage_ip[AW +: AW]), 64'd5);
    cyc(1'b0, 1'b1, 18'h100, 1'b0, 1'b0);
    chk("redirect_bubble", 64'(stage_valid[0]), 64'd0);
    chk("redirect_addr", 64'(code_addr), 64'h100);
    idle(1);
    chk("redirect_addr_next", 64'(code_addr), 64'h101);
    idle(3);

    do_reset();
    idle(9);
    chk("pre_wait_ip1", 64'(stage_ip[AW +: AW]), 64'd7);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    halt_latency(0, 1, "halt_latency");
    idle(10);
    chk("wait_cycles_10", 64'(wait_cycles), 64'd10);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("resume_addr", 64'(code_addr), 64'd8);
    chk("resume_wfc", 64'(wait_for_continue), 64'd0);
    idle(4);

    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(3);
    chk("pass_wait_wfc", 64'(wait_for_continue), 64'd0);

    cyc(1'b0, 1'b1, 18'h3FFFE, 1'b0, 1'b0);
    idle(2);
    chk("wrap_addr", 64'(code_addr), 64'd0);
    idle(2);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    halt_latency(4, 5, "halt_latency_stall");
    idle(3);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom_range(0, 9) == 0);
      rv  = 1'b0;
      wd  = 1'b0;
      rip = AW'($urandom);
      wc  = 1'($urandom_range(0, 1));
      if (m_mode == M_RUN && m_v[DS]) begin
        r = $urandom_range(0, 15);
        if (r == 0) rv = 1'b1;
        else if (r == 1) wd = 1'b1;
        else if (r == 2) begin
          rv = 1'b1;
          wd = 1'b1;
        end
      end
      if (m_mode == M_HALT) wc = ($urandom_range(0, 5) == 0);
      cyc(st, rv, rip, wd, wc);
    end

    @(negedge clock);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
